branch_update_sequencer: RTL

Controller sitting between the execute stage and the branch predictor's single update port. Accepts resolved branch outcomes, detects mispredictions and issues a one-cycle redirect to fetch, and buffers the outcomes in a small FIFO. It drains that FIFO into the predictor one write per cycle, so the predictor's `we`/`update_pc`/`wb_addr`/`branch_taken` port is never driven by more than one source.

---
 rtl/branch_update_sequencer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/branch_update_sequencer.sv
// Branch-resolution front end for the predictor update port: flags mispredicts, buffers outcomes
// and drains them one predictor write per cycle. Define BUS_SEQ_STATS_EN for branch/mispredict counters.
module branch_update_sequencer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       res_valid,
    input  logic [9:0] res_pc,
    input  logic [9:0] res_target,
    input  logic       res_taken,
    input  logic       res_pred_taken,
    input  logic [9:0] res_pred_target,
    input  logic       hold,
    output logic       res_ready,
    output logic       mispredict,
    output logic [9:0] redirect_pc,
    output logic       bp_we,
    output logic [9:0] bp_update_pc,
    output logic [9:0] bp_wb_addr,
    output logic       bp_branch_taken,
    output logic       overflow
`ifdef BUS_SEQ_STATS_EN
    ,
    output logic [15:0] stat_branches,
    output logic [15:0] stat_mispredicts
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 21;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [EW-1:0] entry_q [DEPTH];
    logic [EW-1:0] entry_d [DEPTH];
    logic          mispredict_q, mispredict_d;
    logic [9:0]    redirect_pc_q, redirect_pc_d;
    logic          overflow_q, overflow_d;

    logic          empty;
    logic          full;
    logic          enq;
    logic          pop;
    logic          next_empty;
    logic          mis_now;
    logic [EW-1:0] head;

    // Full when the indices match but the wrap bits differ.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign enq   = res_valid && !full;
    assign pop   = (state_q == S_DRAIN) && !hold && !empty;

    assign mis_now = res_valid &&
                     ((res_taken != res_pred_taken) ||
                      (res_taken && (res_target != res_pred_target)));

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW + 1)'(enq);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
        entry_d  = entry_q;
        if (enq) begin
            entry_d[wr_ptr_q[AW-1:0]] = {res_pc, res_target, res_taken};
        end
    end

    assign next_empty = (wr_ptr_d == rd_ptr_d);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (hold)     state_d = S_HOLD;
                else if (enq) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (hold)            state_d = S_HOLD;
                else if (next_empty) state_d = S_IDLE;
            end
            S_HOLD: begin
                if (!hold) state_d = next_empty ? S_IDLE : S_DRAIN;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Redirect is only loaded on a mispredict, so it holds the last redirect address otherwise.
    always_comb begin
        mispredict_d  = mis_now;
        redirect_pc_d = redirect_pc_q;
        if (mis_now) begin
            redirect_pc_d = res_taken ? res_target : res_pc + 10'd1;
        end
        overflow_d = overflow_q || (res_valid && full);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            mispredict_q  <= 1'b0;
            redirect_pc_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            mispredict_q  <= mispredict_d;
            redirect_pc_q <= redirect_pc_d;
            overflow_q    <= overflow_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) entry_q[gi] <= '0;
                else     entry_q[gi] <= entry_d[gi];
            end
        end
    endgenerate

    assign head            = entry_q[rd_ptr_q[AW-1:0]];
    assign res_ready       = !full;
    assign mispredict      = mispredict_q;
    assign redirect_pc     = redirect_pc_q;
    assign bp_we           = pop;
    assign bp_update_pc    = head[20:11];
    assign bp_wb_addr      = head[10:1];
    assign bp_branch_taken = head[0];
    assign overflow        = overflow_q;

`ifdef BUS_SEQ_STATS_EN
    logic [15:0] stat_branches_q, stat_branches_d;
    logic [15:0] stat_mispredicts_q, stat_mispredicts_d;

    always_comb begin
        stat_branches_d    = stat_branches_q;
        stat_mispredicts_d = stat_mispredicts_q;
        if (enq && (stat_branches_q != 16'hFFFF))        stat_branches_d    = stat_branches_q + 16'd1;
        if (mis_now && (stat_mispredicts_q != 16'hFFFF)) stat_mispredicts_d = stat_mispredicts_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches_q    <= '0;
            stat_mispredicts_q <= '0;
        end else begin
            stat_branches_q    <= stat_branches_d;
            stat_mispredicts_q <= stat_mispredicts_d;
        end
    end

    assign stat_branches    = stat_branches_q;
    assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule
